// File: rtl/initial_orders_loader.sv
// Start-up loader: streams a little-endian byte image into consecutive 16-bit
// memory words through the memwrt/membusy handshake, then flags done.
module initial_orders_loader #(
  parameter int unsigned LOAD_WORDS = 512,
  parameter logic [9:0]  START_ADDR = 10'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [9:0]  Memadr,
  output logic [15:0] memdata_w,
  output logic        memwrt,
  output logic        memrd,
  input  logic        membusy,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {
    L_IDLE,
    L_LO,
    L_HI,
    L_REQ,
    L_WAIT,
    L_DONE
  } state_e;

  localparam logic [10:0] LAST_COUNT = 11'(LOAD_WORDS);

  state_e      state_q, state_d;
  logic [9:0]  count_q, count_d;
  logic [9:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] sum_q, sum_d;
  logic        done_q, done_d;
  logic        pend_q, pend_d;
  logic        go;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= L_IDLE;
      count_q <= '0;
      addr_q  <= START_ADDR;
      data_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    done_d  = done_q;
    pend_d  = pend_q;
    // A start seen while the memory is still busy is remembered until it frees up
    go      = start | pend_q;

    unique case (state_q)
      L_IDLE: begin
        if (go) begin
          if (!membusy) begin
            state_d = L_LO;
            count_d = '0;
            sum_d   = '0;
            done_d  = 1'b0;
            addr_d  = START_ADDR;
            pend_d  = 1'b0;
          end else begin
            pend_d  = 1'b1;
          end
        end
      end
      L_LO: begin
        if (byte_valid) begin
          data_d[7:0] = byte_data;
          state_d     = L_HI;
        end
      end
      L_HI: begin
        if (byte_valid) begin
          data_d[15:8] = byte_data;
          state_d      = L_REQ;
        end
      end
      L_REQ: begin
        if (membusy) begin
          sum_d   = sum_q + data_q;
          state_d = L_WAIT;
        end
      end
      L_WAIT: begin
        if (!membusy) begin
          if (({1'b0, count_q} + 11'd1) == LAST_COUNT) begin
            state_d = L_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + 10'd1;
            addr_d  = addr_q + 10'd1;
            state_d = L_LO;
          end
        end
      end
      L_DONE: begin
        state_d = L_IDLE;
      end
      default: begin
        state_d = L_IDLE;
      end
    endcase
  end

  assign byte_ready = (state_q == L_LO) || (state_q == L_HI);
  assign memwrt     = (state_q == L_REQ);
  assign memrd      = 1'b0;
  assign busy       = (state_q == L_LO) || (state_q == L_HI) ||
                      (state_q == L_REQ) || (state_q == L_WAIT);
  assign done       = done_q;
  assign Memadr     = addr_q;
  assign memdata_w  = data_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_initial_orders_loader.sv
// Bench for initial_orders_loader: two instances (base 0 and wrapping base 1022)
// against a busy-pulse memory model, checked through a write/checksum scoreboard.
module tb_initial_orders_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s [2];
  logic [7:0]  bdata   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic [9:0]  adr     [2];
  logic [15:0] wdat    [2];
  logic        mw      [2];
  logic        mr      [2];
  logic        mb      [2];
  logic        busy    [2];
  logic        done    [2];
  logic [15:0] csum    [2];
  logic [1:0]  mcnt    [2];
  logic [15:0] mem     [2][1024];

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] exp_w0[$];
  logic [25:0] exp_w1[$];
  logic [15:0] exp_c0[$];
  logic [15:0] exp_c1[$];

  logic [7:0]  img   [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  logic [15:0] words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [9:0]  sa    [2] = '{10'd0, 10'd1022};
  localparam logic [15:0] IMG_SUM = 16'hE258;

  initial_orders_loader #(.LOAD_WORDS(4), .START_ADDR(10'd0)) u_a (
    .clock(clk), .reset(rst), .start(start_s[0]),
    .byte_data(bdata[0]), .byte_valid(bvalid[0]), .byte_ready(bready[0]),
    .Memadr(adr[0]), .memdata_w(wdat[0]), .memwrt(mw[0]), .memrd(mr[0]),
    .membusy(mb[0]), .busy(busy[0]), .done(done[0]), .checksum(csum[0])
  );

  initial_orders_loader #(.LOAD_WORDS(4), .START_ADDR(10'd1022)) u_b (
    .clock(clk), .reset(rst), .start(start_s[1]),
    .byte_data(bdata[1]), .byte_valid(bvalid[1]), .byte_ready(bready[1]),
    .Memadr(adr[1]), .memdata_w(wdat[1]), .memwrt(mw[1]), .memrd(mr[1]),
    .membusy(mb[1]), .busy(busy[1]), .done(done[1]), .checksum(csum[1])
  );

  // Memory: latches on memwrt while idle, raises membusy, drops it three edges later
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        mb[g]   <= 1'b0;
        mcnt[g] <= 2'd0;
      end else if (mw[g] && !mb[g]) begin
        mem[g][adr[g]] <= wdat[g];
        mb[g]   <= 1'b1;
        mcnt[g] <= 2'd2;
      end else if (mb[g]) begin
        if (mcnt[g] == 2'd0) mb[g] <= 1'b0;
        else                 mcnt[g] <= mcnt[g] - 2'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_w(input int k, input logic [25:0] v);
    if (k == 0) exp_w0.push_back(v);
    else        exp_w1.push_back(v);
  endtask

  task automatic push_c(input int k, input logic [15:0] v);
    if (k == 0) exp_c0.push_back(v);
    else        exp_c1.push_back(v);
  endtask

  // Monitor: pops the scoreboard on each write capture and on each done rise
  logic mw_p [2];
  logic done_p [2];
  logic busy_p [2];
  int   pulses [2];
  initial begin
    logic [25:0] e;
    logic [15:0] c;
    logic        empty;
    for (int g = 0; g < 2; g++) begin
      mw_p[g] = 1'b0; done_p[g] = 1'b0; busy_p[g] = 1'b0; pulses[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("memrd_%0d", g), {31'd0, mr[g]}, 32'd0);
        if (!rst) begin
          if (busy[g] && !busy_p[g]) pulses[g] = 0;
          if (mw[g] && !mw_p[g]) begin
            chk($sformatf("memwrt_rise_while_busy_%0d", g), {31'd0, mb[g]}, 32'd0);
            pulses[g]++;
          end
          if (bready[g])
            chk($sformatf("byte_ready_in_req_wait_%0d", g), {31'd0, mw[g] | mb[g]}, 32'd0);
          if (mw[g] && !mb[g]) begin
            empty = (g == 0) ? (exp_w0.size() == 0) : (exp_w1.size() == 0);
            if (empty) begin
              chk($sformatf("unexpected_write_%0d", g), 32'd1, 32'd0);
            end else begin
              e = (g == 0) ? exp_w0.pop_front() : exp_w1.pop_front();
              chk($sformatf("wr_addr_%0d", g), {22'd0, adr[g]}, {22'd0, e[25:16]});
              chk($sformatf("wr_data_%0d", g), {16'd0, wdat[g]}, {16'd0, e[15:0]});
            end
          end
          if (done[g] && !done_p[g]) begin
            empty = (g == 0) ? (exp_c0.size() == 0) : (exp_c1.size() == 0);
            if (empty) begin
              chk($sformatf("unexpected_done_%0d", g), 32'd1, 32'd0);
            end else begin
              c = (g == 0) ? exp_c0.pop_front() : exp_c1.pop_front();
              chk($sformatf("checksum_%0d", g), {16'd0, csum[g]}, {16'd0, c});
              chk($sformatf("memwrt_pulses_%0d", g), pulses[g], 32'd4);
            end
          end
        end
        mw_p[g]   = mw[g];
        done_p[g] = done[g];
        busy_p[g] = busy[g];
      end
    end
  end

  task automatic feed(input int k, input int nb, input bit gaps, input bit poke);
    int tmo;
    for (int i = 0; i < nb; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        bvalid[k] = 1'b0;
        @(negedge clk);
      end
      bvalid[k] = 1'b1;
      bdata[k]  = img[i];
      tmo = 0;
      while (!bready[k] && tmo < 500) begin
        @(negedge clk);
        tmo++;
      end
      chk("byte_accept", {31'd0, bready[k]}, 32'd1);
      if (!bready[k]) begin
        bvalid[k] = 1'b0;
        return;
      end
      @(negedge clk);
      // Stray start held high while the loader sits in L_HI
      if (poke && i == 0) start_s[k] = 1'b1;
      if (poke && i == 1) start_s[k] = 1'b0;
    end
    bvalid[k] = 1'b0;
  endtask

  task automatic poke_wait(input int k);
    int n = 0;
    while (!(busy[k] && !mw[k] && mb[k]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("poke_in_wait_reached", {31'd0, busy[k] && !mw[k] && mb[k]}, 32'd1);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic run_load(input int k, input bit gaps, input bit poke, input bit lat);
    for (int i = 0; i < 4; i++) push_w(k, {sa[k] + 10'(i), words[i]});
    push_c(k, IMG_SUM);
    start_s[k] = 1'b1;
    fork
      feed(k, 8, gaps, poke);
      begin
        int n;
        @(negedge clk);
        start_s[k] = 1'b0;
        n = 1;
        chk("start_clears_done", {31'd0, done[k]}, 32'd0);
        chk("start_clears_checksum", {16'd0, csum[k]}, 32'd0);
        chk("start_loads_addr", {22'd0, adr[k]}, {22'd0, sa[k]});
        chk("busy_after_start", {31'd0, busy[k]}, 32'd1);
        while (!done[k] && n < 2000) begin
          @(negedge clk);
          n++;
        end
        chk("done_reached", {31'd0, done[k]}, 32'd1);
        if (lat) chk("load_latency_cycles", n, 32'd29);
      end
      if (poke) poke_wait(k);
    join
    repeat (2) @(negedge clk);
    chk("done_held", {31'd0, done[k]}, 32'd1);
    chk("busy_after_done", {31'd0, busy[k]}, 32'd0);
  endtask

  task automatic run_abort(input int k);
    int n = 0;
    push_w(k, {sa[k], words[0]});
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    feed(k, 2, 1'b0, 1'b0);
    while (!(mw[k] && mb[k]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_req", {31'd0, mw[k] && mb[k]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_memwrt", {31'd0, mw[k]}, 32'd0);
    chk("abort_busy", {31'd0, busy[k]}, 32'd0);
    chk("abort_byte_ready", {31'd0, bready[k]}, 32'd0);
    chk("abort_addr", {22'd0, adr[k]}, {22'd0, sa[k]});
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; bvalid[g] = 1'b0; bdata[g] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_byte_ready", {31'd0, bready[g]}, 32'd0);
      chk("rst_memwrt", {31'd0, mw[g]}, 32'd0);
      chk("rst_busy", {31'd0, busy[g]}, 32'd0);
      chk("rst_done", {31'd0, done[g]}, 32'd0);
      chk("rst_addr", {22'd0, adr[g]}, {22'd0, sa[g]});
      chk("rst_data", {16'd0, wdat[g]}, 32'd0);
      chk("rst_checksum", {16'd0, csum[g]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_load(0, 1'b0, 1'b0, 1'b1);
    run_load(0, 1'b1, 1'b1, 1'b0);
    run_load(1, 1'b0, 1'b0, 1'b1);
    chk("wrap_final_addr", {22'd0, adr[1]}, 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mem_wrap_%0d", i), {16'd0, mem[1][10'(1022 + i)]}, {16'd0, words[i]});

    run_abort(0);
    run_load(0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mem_base_%0d", i), {16'd0, mem[0][i]}, {16'd0, words[i]});

    repeat (2) @(negedge clk);
    chk("writes_left_0", exp_w0.size(), 32'd0);
    chk("writes_left_1", exp_w1.size(), 32'd0);
    chk("sums_left_0", exp_c0.size(), 32'd0);
    chk("sums_left_1", exp_c1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
